// File: rtl/reg_file_16.sv
// reg_file_16: 16-entry register file with write-back scoreboard and two registered read ports.
// Latency: read data and busy flags appear 1 cycle after rd_en; busy_mask reflects state after each edge.
// Backpressure: none; every request is accepted each cycle, so decode stalls on busy_a/busy_b itself.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data write-back strobe, index (decoded one-hot) and data
//   claim_en/claim_addr   mark a register busy (result pending)
//   rd_en/rd_a_addr/rd_b_addr  read request for both ports
//   rd_a_data/rd_b_data   registered read data (write-through bypass)
//   busy_a/busy_b         registered busy flag aligned with read data
//   rd_valid              1-cycle pulse: rd_* / busy_* updated
//   busy_mask             registered scoreboard, bit i = register i busy
module reg_file_16 #(
  parameter int bits     = 16,
  parameter bit zero_reg = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [bits-1:0] wr_data,
  input  logic            claim_en,
  input  logic [3:0]      claim_addr,
  input  logic            rd_en,
  input  logic [3:0]      rd_a_addr,
  input  logic [3:0]      rd_b_addr,
  output logic [bits-1:0] rd_a_data,
  output logic [bits-1:0] rd_b_data,
  output logic            busy_a,
  output logic            busy_b,
  output logic            rd_valid,
  output logic [15:0]     busy_mask
);

  logic [bits-1:0] regs_q [16];
  logic [bits-1:0] regs_d [16];
  logic [15:0]     busy_q, busy_d;
  logic [bits-1:0] rd_a_data_q, rd_a_data_d;
  logic [bits-1:0] rd_b_data_q, rd_b_data_d;
  logic            busy_a_q, busy_a_d;
  logic            busy_b_q, busy_b_d;
  logic            rd_valid_q, rd_valid_d;

  // One-hot write enables and claim (set) vector.
  logic [15:0]     we;
  logic [15:0]     set;

  always_comb begin
    we  = '0;
    set = '0;
    if (wr_en)    we[wr_addr]     = 1'b1;
    if (claim_en) set[claim_addr] = 1'b1;
    // Hard-wired zero register: r0 can never be written or claimed, so it
    // stays at its reset value of 0 and is never busy.
    if (zero_reg) begin
      we[0]  = 1'b0;
      set[0] = 1'b0;
    end

    // Set wins over clear: a same-cycle claim belongs to a newer producer.
    busy_d = set | (busy_q & ~we);

    for (int i = 0; i < 16; i++) begin
      regs_d[i] = we[i] ? wr_data : regs_q[i];
    end

    rd_a_data_d = rd_a_data_q;
    rd_b_data_d = rd_b_data_q;
    busy_a_d    = busy_a_q;
    busy_b_d    = busy_b_q;
    rd_valid_d  = rd_en;
    if (rd_en) begin
      // Bypass the write landing this cycle so the reader sees the new value,
      // and report the scoreboard as it will be after this edge.
      rd_a_data_d = we[rd_a_addr] ? wr_data : regs_q[rd_a_addr];
      rd_b_data_d = we[rd_b_addr] ? wr_data : regs_q[rd_b_addr];
      busy_a_d    = busy_d[rd_a_addr];
      busy_b_d    = busy_d[rd_b_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      rd_a_data_q <= '0;
      rd_b_data_q <= '0;
      busy_a_q    <= 1'b0;
      busy_b_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q      <= busy_d;
      rd_a_data_q <= rd_a_data_d;
      rd_b_data_q <= rd_b_data_d;
      busy_a_q    <= busy_a_d;
      busy_b_q    <= busy_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_a_data = rd_a_data_q;
  assign rd_b_data = rd_b_data_q;
  assign busy_a    = busy_a_q;
  assign busy_b    = busy_b_q;
  assign rd_valid  = rd_valid_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_reg_file_16.sv
// Testbench for reg_file_16: directed vector table plus hand-written
// zero-register sequences on a second instance with zero_reg=1.
module tb_reg_file_16;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic        rd_en;
  logic [3:0]  rd_a_addr, rd_b_addr;

  logic [15:0] rd_a_data, rd_b_data, busy_mask;
  logic        busy_a, busy_b, rd_valid;
  logic [15:0] z_rd_a_data, z_rd_b_data, z_busy_mask;
  logic        z_busy_a, z_busy_b, z_rd_valid;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  reg_file_16 #(.bits(16), .zero_reg(1'b0)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .busy_a(busy_a), .busy_b(busy_b), .rd_valid(rd_valid),
    .busy_mask(busy_mask)
  );

  reg_file_16 #(.bits(16), .zero_reg(1'b1)) dut_z (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(z_rd_a_data), .rd_b_data(z_rd_b_data),
    .busy_a(z_busy_a), .busy_b(z_busy_b), .rd_valid(z_rd_valid),
    .busy_mask(z_busy_mask)
  );

  typedef struct {
    logic        rst;
    logic        wen;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        cen;
    logic [3:0]  ca;
    logic        ren;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eba;
    logic        ebb;
    logic        ev;
    logic [15:0] em;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic wen, input logic [3:0] wa, input logic [15:0] wd,
    input logic cen, input logic [3:0] ca, input logic ren, input logic [3:0] ra,
    input logic [3:0] rb, input logic [15:0] ea, input logic [15:0] eb,
    input logic eba, input logic ebb, input logic ev, input logic [15:0] em);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wa = wa; v.wd = wd; v.cen = cen; v.ca = ca;
    v.ren = ren; v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
    v.eba = eba; v.ebb = ebb; v.ev = ev; v.em = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at negedge), then wait to the next negedge.
  task automatic drive(input logic rst, input logic wen, input logic [3:0] wa,
                       input logic [15:0] wd, input logic cen, input logic [3:0] ca,
                       input logic ren, input logic [3:0] ra, input logic [3:0] rb);
    reset = rst; wr_en = wen; wr_addr = wa; wr_data = wd;
    claim_en = cen; claim_addr = ca; rd_en = ren; rd_a_addr = ra; rd_b_addr = rb;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; rd_en = 1'b0; rd_a_addr = '0; rd_b_addr = '0;

    //               rst wen wa  wd        cen ca  ren ra  rb   ea        eb        eba ebb ev  em
    vecs.push_back(mk(1, 0, 0,  16'h0000, 0, 0,  0, 0,  0,  16'h0000, 16'h0000, 0, 0, 0, 16'h0000)); // reset
    vecs.push_back(mk(0, 1, 3,  16'hBEEF, 0, 0,  0, 0,  0,  16'h0000, 16'h0000, 0, 0, 0, 16'h0000)); // wr r3
    vecs.push_back(mk(1, 1, 3,  16'h1111, 1, 3,  1, 3,  3,  16'h0000, 16'h0000, 0, 0, 0, 16'h0000)); // reset overrides all
    vecs.push_back(mk(0, 0, 0,  16'h0000, 0, 0,  1, 3,  3,  16'h0000, 16'h0000, 0, 0, 1, 16'h0000)); // r3 cleared
    vecs.push_back(mk(0, 1, 5,  16'h1234, 0, 0,  0, 0,  0,  16'h0000, 16'h0000, 0, 0, 0, 16'h0000)); // wr r5
    vecs.push_back(mk(0, 0, 0,  16'h0000, 0, 0,  1, 5,  5,  16'h1234, 16'h1234, 0, 0, 1, 16'h0000)); // A=B=r5
    vecs.push_back(mk(0, 1, 7,  16'hA5A5, 0, 0,  1, 7,  5,  16'hA5A5, 16'h1234, 0, 0, 1, 16'h0000)); // bypass r7
    vecs.push_back(mk(0, 0, 0,  16'h0000, 0, 0,  0, 0,  0,  16'hA5A5, 16'h1234, 0, 0, 0, 16'h0000)); // hold
    vecs.push_back(mk(0, 0, 0,  16'h0000, 1, 9,  0, 0,  0,  16'hA5A5, 16'h1234, 0, 0, 0, 16'h0200)); // claim r9
    vecs.push_back(mk(0, 0, 0,  16'h0000, 0, 0,  1, 9,  7,  16'h0000, 16'hA5A5, 1, 0, 1, 16'h0200)); // r9 busy
    vecs.push_back(mk(0, 1, 9,  16'h0909, 0, 0,  1, 9,  9,  16'h0909, 16'h0909, 0, 0, 1, 16'h0000)); // wr clears r9
    vecs.push_back(mk(0, 0, 0,  16'h0000, 1, 2,  0, 0,  0,  16'h0909, 16'h0909, 0, 0, 0, 16'h0004)); // claim r2
    vecs.push_back(mk(0, 1, 2,  16'h2222, 1, 2,  1, 2,  9,  16'h2222, 16'h0909, 1, 0, 1, 16'h0004)); // claim+wr r2
    vecs.push_back(mk(0, 0, 0,  16'h0000, 0, 0,  1, 2,  3,  16'h2222, 16'h0000, 1, 0, 1, 16'h0004)); // r2 still busy
    vecs.push_back(mk(0, 1, 2,  16'h3333, 1, 4,  1, 4,  2,  16'h0000, 16'h3333, 1, 0, 1, 16'h0010)); // clr r2, set r4
    vecs.push_back(mk(0, 0, 0,  16'h0000, 1, 4,  1, 4,  4,  16'h0000, 16'h0000, 1, 1, 1, 16'h0010)); // re-claim r4
    vecs.push_back(mk(0, 1, 15, 16'hFFFF, 1, 0,  1, 15, 0,  16'hFFFF, 16'h0000, 0, 1, 1, 16'h0011)); // r15, claim r0
    vecs.push_back(mk(0, 1, 0,  16'h00AA, 0, 0,  1, 0,  4,  16'h00AA, 16'h0000, 0, 1, 1, 16'h0010)); // r0 normal reg
    vecs.push_back(mk(0, 1, 4,  16'h4444, 0, 0,  0, 0,  0,  16'h00AA, 16'h0000, 0, 1, 0, 16'h0000)); // hold, clr r4
    vecs.push_back(mk(1, 0, 0,  16'h0000, 0, 0,  0, 0,  0,  16'h0000, 16'h0000, 0, 0, 0, 16'h0000)); // reset
    vecs.push_back(mk(0, 0, 0,  16'h0000, 0, 0,  1, 15, 4,  16'h0000, 16'h0000, 0, 0, 1, 16'h0000)); // all zero

    @(negedge clock);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].cen, vecs[i].ca,
            vecs[i].ren, vecs[i].ra, vecs[i].rb);
      check($sformatf("v%0d rd_a_data", i), 32'(rd_a_data), 32'(vecs[i].ea));
      check($sformatf("v%0d rd_b_data", i), 32'(rd_b_data), 32'(vecs[i].eb));
      check($sformatf("v%0d busy_a", i),    32'(busy_a),    32'(vecs[i].eba));
      check($sformatf("v%0d busy_b", i),    32'(busy_b),    32'(vecs[i].ebb));
      check($sformatf("v%0d rd_valid", i),  32'(rd_valid),  32'(vecs[i].ev));
      check($sformatf("v%0d busy_mask", i), 32'(busy_mask), 32'(vecs[i].em));
    end

    // Zero register: write+claim r0 while reading it in the same cycle.
    drive(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 16'hFFFF, 1, 0, 1, 0, 0);
    check("z0 rd_a_data", 32'(z_rd_a_data), 32'h0);
    check("z0 busy_a",    32'(z_busy_a),    32'h0);
    check("z0 busy_mask", 32'(z_busy_mask), 32'h0);
    check("n0 rd_a_data", 32'(rd_a_data),   32'hFFFF);
    check("n0 busy_a",    32'(busy_a),      32'h1);
    check("n0 busy_mask", 32'(busy_mask),   32'h0001);
    // Read r0 again after the write settled.
    drive(0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    check("z1 rd_b_data", 32'(z_rd_b_data), 32'h0);
    check("z1 busy_b",    32'(z_busy_b),    32'h0);
    check("z1 rd_valid",  32'(z_rd_valid),  32'h1);
    check("n1 rd_b_data", 32'(rd_b_data),   32'hFFFF);
    // Other registers behave normally with zero_reg=1.
    drive(0, 1, 1, 16'h0101, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 16'h0000, 1, 1, 1, 1, 0);
    check("z2 rd_a_data", 32'(z_rd_a_data), 32'h0101);
    check("z2 busy_a",    32'(z_busy_a),    32'h1);
    check("z2 rd_b_data", 32'(z_rd_b_data), 32'h0);
    check("z2 busy_mask", 32'(z_busy_mask), 32'h0002);
    check("n2 busy_mask", 32'(busy_mask),   32'h0003);
    // rd_valid drops back after a single pulse.
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    check("z3 rd_valid",  32'(z_rd_valid),  32'h0);
    check("z3 rd_a_data", 32'(z_rd_a_data), 32'h0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
